imm_gen_stage: RTL and testbench

- Registered, parametrised immediate generator for the pipelined RISC-V core, placed between decode and the execute-stage operand mux.
- Decodes six immediate formats (I, S, B, J, U, Z) and sign- or zero-extends each to XLEN.
- Carries a sideband tag alongside the immediate.
- Provides a 2-entry skid buffer with valid/ready handshakes on both sides and a synchronous flush.

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_decode.sv | 38 +++
 rtl/imm_gen_stage.sv | 135 +++++++++++++
 tb/tb_imm_gen_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate generator.
// imm_src format codes and the legal XLEN values.
`timescale 1ns/1ps
package imm_pkg;

    typedef logic [2:0] immSrc_t;

    localparam immSrc_t IMM_I = 3'b000;
    localparam immSrc_t IMM_S = 3'b001;
    localparam immSrc_t IMM_B = 3'b010;
    localparam immSrc_t IMM_J = 3'b011;
    localparam immSrc_t IMM_U = 3'b100;
    localparam immSrc_t IMM_Z = 3'b101;

    localparam int unsigned XLEN_32 = 32;
    localparam int unsigned XLEN_64 = 64;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: instr[31:7] and format select to an XLEN value.
// Reserved formats yield zero and raise err.
`timescale 1ns/1ps
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_32
) (
    input  logic [24:0]     instr,
    input  immSrc_t         immSrc,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Indexed with the architectural bit numbers of the full instruction word.
    logic [31:7] ir;
    logic [31:0] val;

    assign ir = instr;

    always_comb begin
        val = '0;
        err = 1'b0;
        case (immSrc)
            IMM_I:   val = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   val = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   val = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   val = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            IMM_U:   val = {ir[31:12], 12'b0};
            IMM_Z:   val = {27'b0, ir[19:15]};
            default: err = 1'b1;
        endcase
        // Every format is already correct in 32 bits; widen by copying bit 31.
        imm       = {XLEN{val[31]}};
        imm[31:0] = val;
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator with a 2-entry skid buffer and synchronous flush.
// Define IMM_GEN_ERR_CHK_EN to store and report a per-entry reserved-format error bit.
`timescale 1ns/1ps
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      instr,
    input  logic [2:0]       imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    logic [XLEN-1:0]  decImm;
    logic             decErr;
    logic             mainValid, mainValidNext;
    logic             skidValid, skidValidNext;
    logic [XLEN-1:0]  mainImm, skidImm;
    logic [TAG_W-1:0] mainTag, skidTag;
    logic             accept, emit;
    logic             loadMain, loadSkid, moveSkid;

    imm_decode #(
        .XLEN (XLEN)
    ) uDecode (
        .instr  (instr),
        .immSrc (imm_src),
        .imm    (decImm),
        .err    (decErr)
    );

    assign in_ready  = ~skidValid;
    assign out_valid = mainValid;
    assign imm       = mainImm;
    assign out_tag   = mainTag;
    assign accept    = in_valid & in_ready;
    assign emit      = mainValid & out_ready;

    always_comb begin
        mainValidNext = mainValid;
        skidValidNext = skidValid;
        loadMain      = 1'b0;
        loadSkid      = 1'b0;
        moveSkid      = 1'b0;
        if (flush) begin
            mainValidNext = 1'b0;
            skidValidNext = 1'b0;
        end else if (skidValid) begin
            // in_ready is low here, so only the skid-to-main move can happen.
            if (emit) begin
                moveSkid      = 1'b1;
                skidValidNext = 1'b0;
            end
        end else if (accept) begin
            if (!mainValid || emit) begin
                loadMain      = 1'b1;
                mainValidNext = 1'b1;
            end else begin
                loadSkid      = 1'b1;
                skidValidNext = 1'b1;
            end
        end else if (emit) begin
            mainValidNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else begin
            mainValid <= mainValidNext;
            skidValid <= skidValidNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainImm <= '0;
            mainTag <= '0;
            skidImm <= '0;
            skidTag <= '0;
        end else begin
            if (loadMain) begin
                mainImm <= decImm;
                mainTag <= in_tag;
            end else if (moveSkid) begin
                mainImm <= skidImm;
                mainTag <= skidTag;
            end
            if (loadSkid) begin
                skidImm <= decImm;
                skidTag <= in_tag;
            end
        end
    end

`ifdef IMM_GEN_ERR_CHK_EN
    logic mainErr, skidErr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mainErr <= 1'b0;
            skidErr <= 1'b0;
        end else begin
            if (loadMain) begin
                mainErr <= decErr;
            end else if (moveSkid) begin
                mainErr <= skidErr;
            end
            if (loadSkid) begin
                skidErr <= decErr;
            end
        end
    end

    assign imm_err = mainValid & mainErr;
`else
    logic unusedDecErr;
    assign unusedDecErr = decErr;
    assign imm_err      = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: 32- and 64-bit instances share one input stream.
`timescale 1ns/1ps
module tb_imm_gen_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [24:0] instr;
    logic [2:0]  imm_src;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, imm_err;
    logic [31:0] imm32;
    logic [7:0]  out_tag;
    logic        in_ready64, out_valid64, imm_err64;
    logic [63:0] imm64;
    logic [7:0]  out_tag64;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    logic [7:0] emitQ[$];
    int         emitCyc[$];

`ifdef IMM_GEN_ERR_CHK_EN
    localparam logic ErrExp = 1'b1;
`else
    localparam logic ErrExp = 1'b0;
`endif

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .imm(imm32), .out_tag(out_tag), .imm_err(imm_err)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .imm_src(imm_src), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .imm(imm64), .out_tag(out_tag64), .imm_err(imm_err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && out_valid && out_ready) begin
            emitQ.push_back(out_tag);
            emitCyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] word, input logic [2:0] src, input logic [7:0] tag);
        in_valid = 1'b1;
        instr    = word[31:7];
        imm_src  = src;
        in_tag   = tag;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; imm_src = '0;
        in_tag = '0; out_ready = 1'b0;
        #3;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (imm32 !== 32'h0) $display("FAIL reset_imm: got %h want 0", imm32); else passed++;
        total++; if (out_tag !== 8'h0) $display("FAIL reset_tag: got %h want 0", out_tag); else passed++;
        total++; if (imm_err !== 1'b0) $display("FAIL reset_err: got %b want 0", imm_err); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (in_ready64 !== 1'b1) $display("FAIL reset_in_ready64: got %b want 1", in_ready64); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL post_reset: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        else passed++;
    endtask

    task automatic test_formats();
        logic [31:0] words[6];
        logic [2:0]  srcs[6];
        logic [31:0] exp32[6];
        logic [63:0] exp64[6];
        words[0] = 32'hFFF00093; srcs[0] = 3'b000; exp32[0] = 32'hFFFFFFFF; exp64[0] = 64'hFFFFFFFFFFFFFFFF;
        words[1] = 32'hFE112C23; srcs[1] = 3'b001; exp32[1] = 32'hFFFFFFF8; exp64[1] = 64'hFFFFFFFFFFFFFFF8;
        words[2] = 32'hFE000EE3; srcs[2] = 3'b010; exp32[2] = 32'hFFFFFFFC; exp64[2] = 64'hFFFFFFFFFFFFFFFC;
        words[3] = 32'h123452B7; srcs[3] = 3'b100; exp32[3] = 32'h12345000; exp64[3] = 64'h0000000012345000;
        words[4] = 32'hFF9FF06F; srcs[4] = 3'b011; exp32[4] = 32'hFFFFFFF8; exp64[4] = 64'hFFFFFFFFFFFFFFF8;
        words[5] = 32'h000F8073; srcs[5] = 3'b101; exp32[5] = 32'h0000001F; exp64[5] = 64'h000000000000001F;
        out_ready = 1'b1;
        // Back-to-back: each beat's result appears one cycle after its offer.
        for (int i = 0; i < 6; i++) begin
            offer(words[i], srcs[i], 8'h40 + 8'(i));
            step();
            total++; if (out_valid !== 1'b1 || out_valid64 !== 1'b1)
                $display("FAIL fmt%0d_valid: got %b/%b want 1/1", i, out_valid, out_valid64);
            else passed++;
            total++; if (imm32 !== exp32[i]) $display("FAIL fmt%0d_imm32: got %h want %h", i, imm32, exp32[i]); else passed++;
            total++; if (imm64 !== exp64[i]) $display("FAIL fmt%0d_imm64: got %h want %h", i, imm64, exp64[i]); else passed++;
            total++; if (out_tag !== 8'h40 + 8'(i) || out_tag64 !== 8'h40 + 8'(i))
                $display("FAIL fmt%0d_tag: got %h/%h want %h", i, out_tag, out_tag64, 8'h40 + 8'(i));
            else passed++;
        end
        in_valid = 1'b0;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL fmt_drain: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_reserved();
        out_ready = 1'b1;
        offer(32'hFFFFFFFF, 3'b110, 8'h76);
        step();
        total++; if (imm32 !== 32'h0 || imm64 !== 64'h0)
            $display("FAIL rsv6_imm: got %h/%h want 0", imm32, imm64);
        else passed++;
        total++; if (imm_err !== ErrExp) $display("FAIL rsv6_err: got %b want %b", imm_err, ErrExp); else passed++;
        offer(32'hFFFFFFFF, 3'b111, 8'h77);
        step();
        total++; if (imm32 !== 32'h0) $display("FAIL rsv7_imm: got %h want 0", imm32); else passed++;
        total++; if (imm_err !== ErrExp || imm_err64 !== ErrExp)
            $display("FAIL rsv7_err: got %b/%b want %b", imm_err, imm_err64, ErrExp);
        else passed++;
        offer(32'hFFF00093, 3'b000, 8'h78);
        step();
        total++; if (imm_err !== 1'b0 || imm32 !== 32'hFFFFFFFF)
            $display("FAIL rsv_next_beat: got err=%b imm=%h want err=0 imm=ffffffff", imm_err, imm32);
        else passed++;
        in_valid = 1'b0;
        step();
        total++; if (imm_err !== 1'b0) $display("FAIL rsv_idle_err: got %b want 0", imm_err); else passed++;
    endtask

    task automatic test_backpressure();
        emitQ.delete(); emitCyc.delete();
        out_ready = 1'b0;
        offer(32'hFFF00093, 3'b000, 8'd1);
        step();
        total++; if (in_ready !== 1'b1 || out_tag !== 8'd1)
            $display("FAIL bp_first: got rdy=%b tag=%0d want rdy=1 tag=1", in_ready, out_tag);
        else passed++;
        offer(32'hFFF00093, 3'b000, 8'd2);
        step();
        total++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", in_ready); else passed++;
        offer(32'hFFF00093, 3'b000, 8'd3);
        step();
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_tag !== 8'd1)
            $display("FAIL bp_hold: got rdy=%b vld=%b tag=%0d want 0 1 1", in_ready, out_valid, out_tag);
        else passed++;
        out_ready = 1'b1;
        step();
        total++; if (out_tag !== 8'd2 || in_ready !== 1'b1)
            $display("FAIL bp_move: got tag=%0d rdy=%b want tag=2 rdy=1", out_tag, in_ready);
        else passed++;
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_tag !== 8'd3)
            $display("FAIL bp_third: got vld=%b tag=%0d want 1 3", out_valid, out_tag);
        else passed++;
        step();
        total++; if (out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", out_valid); else passed++;
        total++; if (emitQ.size() !== 3) $display("FAIL bp_count: got %0d want 3", emitQ.size());
        else begin
            if (emitQ[0] !== 8'd1 || emitQ[1] !== 8'd2 || emitQ[2] !== 8'd3)
                $display("FAIL bp_order: got %0d,%0d,%0d want 1,2,3", emitQ[0], emitQ[1], emitQ[2]);
            else if (emitCyc[1] != emitCyc[0] + 1 || emitCyc[2] != emitCyc[1] + 1)
                $display("FAIL bp_gaps: got cycles %0d,%0d,%0d want consecutive",
                         emitCyc[0], emitCyc[1], emitCyc[2]);
            else passed++;
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h123452B7, 3'b100, 8'h10);
        step();
        offer(32'h123452B7, 3'b100, 8'h11);
        step();
        offer(32'h123452B7, 3'b100, 8'h12);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_full: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else passed++;
        // Flush while the stage could otherwise accept: the offered item must not land.
        offer(32'h123452B7, 3'b100, 8'h20);
        step();
        offer(32'h123452B7, 3'b100, 8'h21);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_main: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else passed++;
        emitQ.delete(); emitCyc.delete();
        out_ready = 1'b1;
        step();
        step();
        total++; if (out_valid !== 1'b0 || emitQ.size() !== 0)
            $display("FAIL flush_absent: got vld=%b emits=%0d want 0 0", out_valid, emitQ.size());
        else passed++;
        offer(32'h000F8073, 3'b101, 8'h30);
        step();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_tag !== 8'h30 || imm32 !== 32'h1F)
            $display("FAIL flush_recover: got vld=%b tag=%h imm=%h want 1 30 1f", out_valid, out_tag, imm32);
        else passed++;
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        offer(32'h123452B7, 3'b100, 8'h55);
        step();
        offer(32'hFFF00093, 3'b000, 8'h56);
        step();
        total++; if (imm32 !== 32'h12345000 || in_ready !== 1'b0)
            $display("FAIL ar_setup: got imm=%h rdy=%b want 12345000 0", imm32, in_ready);
        else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || imm32 !== 32'h0 || out_tag !== 8'h0)
            $display("FAIL ar_async: got vld=%b imm=%h tag=%h want 0 0 0", out_valid, imm32, out_tag);
        else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL ar_ready: got %b want 1", in_ready); else passed++;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        total++; if (out_valid !== 1'b0 || imm32 !== 32'h0)
            $display("FAIL ar_no_survivor: got vld=%b imm=%h want 0 0", out_valid, imm32);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_reserved();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
